bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single 16-bit address / 8-bit data memory bus between two bus masters.
- Master 0 is the CPU core; master 1 is an auxiliary master (program loader / debug port).
- Each master sees a private copy of the CPU-style bus protocol: hold read/write until wait drops.
- The arbiter grants one master at a time, forwards its cycle downstream, and holds each master's last read data so the master can consume it in later cycles.

Parameters:
- ADDR_WIDTH, 16, address width of masters and downstream bus.
- DATA_WIDTH, 8, data width.
- FIXED_PRIORITY, 0, 0 = round-robin between masters; 1 = master 0 always wins contention.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_bus_address  in  ADDR_WIDTH  master 0 address.
- m0_bus_data_out  in  DATA_WIDTH  master 0 write data.
- m0_bus_data_in  out  DATA_WIDTH  master 0 read data.
- m0_bus_read  in  1  master 0 read request (level, held until complete).
- m0_bus_write  in  1  master 0 write request.
- m0_bus_wait  out  1  1 = master 0 must keep holding its request.
- m1_bus_address, m1_bus_data_out, m1_bus_data_in, m1_bus_read, m1_bus_write, m1_bus_wait: same as master 0, for master 1.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_data_out  out  DATA_WIDTH  downstream write data.
- mem_data_in  in  DATA_WIDTH  downstream read data, valid when mem_wait=0.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_wait  in  1  downstream busy.
- grant  out  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 = idle.

Behaviour:
- Requests: reqN = mN_bus_read | mN_bus_write. Read and write both asserted is treated as a write (mem_read = read & ~write).
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: master 0 / master 1 owns the bus.
  - State is registered; grant is decoded from it.
- IDLE transitions:
  - Only req0 -> OWN0; only req1 -> OWN1.
  - Both: FIXED_PRIORITY=1 -> OWN0. Otherwise the master not recorded in last_owner wins.
  - Neither: stay in IDLE.
- OWNn transitions:
  - Completion (reqn & !mem_wait at the edge): -> IDLE; last_owner <= n; if the cycle is a read, rdata_hold[n] <= mem_data_in.
  - Abort (reqn dropped before completion): -> IDLE; last_owner unchanged; rdata_hold unchanged.
  - Otherwise stay in OWNn.
- Latency:
  - The cycle in which a request first appears always sees mN_bus_wait=1 (grant is registered).
  - With zero-wait memory, a lone request completes on its 2nd asserted cycle.
  - Minimum one IDLE cycle between consecutive ownerships (re-arbitration cycle).
- Downstream mux (combinational on grant):
  - In OWNn: mem_address / mem_data_out / mem_read / mem_write come from master n.
  - In IDLE: all downstream outputs are 0.
- Waits:
  - mN_bus_wait = mem_wait when state is OWNN; otherwise 1.
  - A non-owner, or an idle master, always sees wait=1.
- Read data:
  - mN_bus_data_in = mem_data_in while in OWNN, so the master samples correct data on the completion edge.
  - Otherwise it is rdata_hold[N]. Data remains stable after completion until that master's next read completes.
- Writes never modify rdata_hold.
- Reset (rst=1 at an edge, including mid-transaction):
  - state = IDLE; grant = 00; last_owner = 1, so M0 wins the first contention.
  - rdata_hold[0] = rdata_hold[1] = 0.
  - mem_read = mem_write = 0; mem_address = mem_data_out = 0; m0/m1_bus_wait = 1.
  - Any in-flight downstream cycle is dropped without completion.
- No starvation in round-robin mode: under continuous contention, ownership alternates M0, M1, M0...

Test Plan:
- Lone read, zero-wait memory: M0 reads 0x1234 with mem returning 0xA5. Cycle 1: m0_wait=1, grant=00. Cycle 2: grant=01, mem_read=1, mem_address=0x1234, m0_wait=0, m0_data_in=0xA5. After M0 drops read: m0_data_in stays 0xA5, grant=00.
- Contention, round-robin: M0 and M1 request on the same cycle after reset -> M0 served first while M1 sees wait=1. Idle cycle, then M1 served. If both re-request, M0 is served next.
- FIXED_PRIORITY=1: M0 requests continuously with 1-cycle gaps while M1 holds a request -> M1 is granted only in cycles where req0=0 at arbitration.
- Wait stretching and write: M1 writes 0x5A to 0x8000 with mem_wait=1 for 3 cycles. m1_wait=1 throughout; mem_write=1 and mem_data_out=0x5A held stable. Completion on the 4th owned cycle. rdata_hold[1] is unchanged.
- Abort and reset: M0 drops read while mem_wait=1 -> IDLE, rdata_hold[0] unchanged. Separately, asserting rst during OWN1 -> next cycle grant=00, mem_read=0, both waits=1, both hold registers=0x00.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for a shared CPU-style memory bus: registered one-hot grant,
// downstream mux on the owner, and per-master hold registers for completed read data.
module bus_arbiter #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_bus_address,
   input  logic [DATA_WIDTH-1:0] m0_bus_data_out,
   output logic [DATA_WIDTH-1:0] m0_bus_data_in,
   input  logic                  m0_bus_read,
   input  logic                  m0_bus_write,
   output logic                  m0_bus_wait,
   input  logic [ADDR_WIDTH-1:0] m1_bus_address,
   input  logic [DATA_WIDTH-1:0] m1_bus_data_out,
   output logic [DATA_WIDTH-1:0] m1_bus_data_in,
   input  logic                  m1_bus_read,
   input  logic                  m1_bus_write,
   output logic                  m1_bus_wait,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic                  mem_wait,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_last_owner;
   logic [DATA_WIDTH-1:0] r_hold0;
   logic [DATA_WIDTH-1:0] r_hold1;

   logic w_req0, w_req1;
   logic w_rd0, w_rd1;
   logic w_done0, w_done1;

   assign w_req0  = m0_bus_read | m0_bus_write;
   assign w_req1  = m1_bus_read | m1_bus_write;
   assign w_rd0   = m0_bus_read & ~m0_bus_write;
   assign w_rd1   = m1_bus_read & ~m1_bus_write;
   assign w_done0 = (r_state == S_OWN0) & w_req0 & ~mem_wait;
   assign w_done1 = (r_state == S_OWN1) & w_req1 & ~mem_wait;

   // Both completion and abort return to IDLE, forcing a re-arbitration cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req0 && w_req1) begin
               if (FIXED_PRIORITY != 0 || r_last_owner) w_next = S_OWN0;
               else                                     w_next = S_OWN1;
            end else if (w_req0) begin
               w_next = S_OWN0;
            end else if (w_req1) begin
               w_next = S_OWN1;
            end
         end
         S_OWN0:  if (!w_req0 || !mem_wait) w_next = S_IDLE;
         S_OWN1:  if (!w_req1 || !mem_wait) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_owner <= 1'b1;
         r_hold0      <= '0;
         r_hold1      <= '0;
      end else begin
         r_state <= w_next;
         if (w_done0) begin
            r_last_owner <= 1'b0;
            if (w_rd0) r_hold0 <= mem_data_in;
         end
         if (w_done1) begin
            r_last_owner <= 1'b1;
            if (w_rd1) r_hold1 <= mem_data_in;
         end
      end
   end

   always_comb begin
      mem_address    = '0;
      mem_data_out   = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      m0_bus_wait    = 1'b1;
      m1_bus_wait    = 1'b1;
      m0_bus_data_in = r_hold0;
      m1_bus_data_in = r_hold1;
      case (r_state)
         S_OWN0: begin
            mem_address    = m0_bus_address;
            mem_data_out   = m0_bus_data_out;
            mem_read       = w_rd0;
            mem_write      = m0_bus_write;
            m0_bus_wait    = mem_wait;
            m0_bus_data_in = mem_data_in;
         end
         S_OWN1: begin
            mem_address    = m1_bus_address;
            mem_data_out   = m1_bus_data_out;
            mem_read       = w_rd1;
            mem_write      = m1_bus_write;
            m1_bus_wait    = mem_wait;
            m1_bus_data_in = mem_data_in;
         end
         default: ;
      endcase
   end

   assign grant = {r_state == S_OWN1, r_state == S_OWN0};

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: round-robin and fixed-priority instances share
// stimulus; a behavioural owner/hold model predicts every output each cycle.
module tb_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] addr [2];
   logic [7:0]  wdat [2];
   logic        rd   [2];
   logic        wr   [2];
   logic [7:0]  mem_din;
   logic        mem_wait;

   // index 0 = round-robin instance, 1 = fixed-priority instance
   logic [15:0] o_maddr [2];
   logic [7:0]  o_mdout [2];
   logic        o_mrd   [2];
   logic        o_mwr   [2];
   logic [1:0]  o_grant [2];
   logic [7:0]  o_d0    [2];
   logic [7:0]  o_d1    [2];
   logic        o_w0    [2];
   logic        o_w1    [2];

   bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIORITY(0)) dut_rr (
      .clk(clk), .rst(rst),
      .m0_bus_address(addr[0]), .m0_bus_data_out(wdat[0]), .m0_bus_data_in(o_d0[0]),
      .m0_bus_read(rd[0]), .m0_bus_write(wr[0]), .m0_bus_wait(o_w0[0]),
      .m1_bus_address(addr[1]), .m1_bus_data_out(wdat[1]), .m1_bus_data_in(o_d1[0]),
      .m1_bus_read(rd[1]), .m1_bus_write(wr[1]), .m1_bus_wait(o_w1[0]),
      .mem_address(o_maddr[0]), .mem_data_out(o_mdout[0]), .mem_data_in(mem_din),
      .mem_read(o_mrd[0]), .mem_write(o_mwr[0]), .mem_wait(mem_wait), .grant(o_grant[0])
   );

   bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .FIXED_PRIORITY(1)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_bus_address(addr[0]), .m0_bus_data_out(wdat[0]), .m0_bus_data_in(o_d0[1]),
      .m0_bus_read(rd[0]), .m0_bus_write(wr[0]), .m0_bus_wait(o_w0[1]),
      .m1_bus_address(addr[1]), .m1_bus_data_out(wdat[1]), .m1_bus_data_in(o_d1[1]),
      .m1_bus_read(rd[1]), .m1_bus_write(wr[1]), .m1_bus_wait(o_w1[1]),
      .mem_address(o_maddr[1]), .mem_data_out(o_mdout[1]), .mem_data_in(mem_din),
      .mem_read(o_mrd[1]), .mem_write(o_mwr[1]), .mem_wait(mem_wait), .grant(o_grant[1])
   );

   typedef struct {
      logic [1:0]  grant;
      logic [15:0] maddr;
      logic [7:0]  mdout;
      logic        mrd;
      logic        mwr;
      logic        w0;
      logic        w1;
      logic [7:0]  d0;
      logic [7:0]  d1;
   } exp_t;

   typedef struct {
      int             owner;   // -1 = nobody
      int             last;
      logic [1:0][7:0] hold;
   } model_t;

   exp_t   q_rr[$];
   exp_t   q_fp[$];
   model_t mdl [2];
   int     n_err = 0;
   int     n_chk = 0;

   function automatic model_t reset_model();
      model_t m;
      m.owner = -1;
      m.last  = 1;
      m.hold  = '0;
      return m;
   endfunction

   function automatic exp_t predict(model_t m);
      exp_t e;
      e.grant = (m.owner == 0) ? 2'b01 : (m.owner == 1) ? 2'b10 : 2'b00;
      e.maddr = '0;
      e.mdout = '0;
      e.mrd   = 1'b0;
      e.mwr   = 1'b0;
      e.w0    = 1'b1;
      e.w1    = 1'b1;
      e.d0    = m.hold[0];
      e.d1    = m.hold[1];
      if (m.owner >= 0) begin
         e.maddr = addr[m.owner];
         e.mdout = wdat[m.owner];
         e.mrd   = rd[m.owner] & ~wr[m.owner];
         e.mwr   = wr[m.owner];
         if (m.owner == 0) begin
            e.w0 = mem_wait;
            e.d0 = mem_din;
         end else begin
            e.w1 = mem_wait;
            e.d1 = mem_din;
         end
      end
      return e;
   endfunction

   function automatic model_t step(model_t m, bit fixed);
      bit r [2];
      int n;
      r[0] = rd[0] | wr[0];
      r[1] = rd[1] | wr[1];
      if (rst) return reset_model();
      if (m.owner < 0) begin
         if (r[0] && r[1]) m.owner = fixed ? 0 : 1 - m.last;
         else if (r[0])    m.owner = 0;
         else if (r[1])    m.owner = 1;
      end else begin
         n = m.owner;
         if (!r[n]) begin
            m.owner = -1;
         end else if (!mem_wait) begin
            if (rd[n] && !wr[n]) m.hold[n] = mem_din;
            m.last  = n;
            m.owner = -1;
         end
      end
      return m;
   endfunction

   task automatic chk(string nm, int d, int unsigned act, int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut=%s t=%0t got=%0h exp=%0h", nm, d ? "fp" : "rr", $time, act, exp);
      end
   endtask

   task automatic compare(int d, exp_t e);
      chk("grant",        d, o_grant[d], e.grant);
      chk("mem_address",  d, o_maddr[d], e.maddr);
      chk("mem_data_out", d, o_mdout[d], e.mdout);
      chk("mem_read",     d, o_mrd[d],   e.mrd);
      chk("mem_write",    d, o_mwr[d],   e.mwr);
      chk("m0_wait",      d, o_w0[d],    e.w0);
      chk("m1_wait",      d, o_w1[d],    e.w1);
      chk("m0_data_in",   d, o_d0[d],    e.d0);
      chk("m1_data_in",   d, o_d1[d],    e.d1);
   endtask

   always @(negedge clk) begin
      if (q_rr.size() > 0) compare(0, q_rr.pop_front());
      if (q_fp.size() > 0) compare(1, q_fp.pop_front());
   end

   // Publish expectations for the current cycle, then advance the model across the edge.
   task automatic cyc();
      q_rr.push_back(predict(mdl[0]));
      q_fp.push_back(predict(mdl[1]));
      @(posedge clk);
      mdl[0] = step(mdl[0], 1'b0);
      mdl[1] = step(mdl[1], 1'b1);
      #1;
   endtask

   task automatic set_m(int n, logic r, logic w, logic [15:0] a, logic [7:0] d);
      rd[n]   = r;
      wr[n]   = w;
      addr[n] = a;
      wdat[n] = d;
   endtask

   task automatic rand_cycle();
      int k;
      for (int n = 0; n < 2; n++) begin
         if (rd[n] | wr[n]) begin
            if ($urandom_range(0, 9) == 0) set_m(n, 1'b0, 1'b0, addr[n], wdat[n]);
         end else if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 2);
            set_m(n, k != 1, k != 0, 16'($urandom), 8'($urandom));
         end
      end
      mem_wait = ($urandom_range(0, 3) == 0);
      mem_din  = 8'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      set_m(0, 1'b0, 1'b0, '0, '0);
      set_m(1, 1'b0, 1'b0, '0, '0);
      mem_din  = 8'h00;
      mem_wait = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mdl[0] = reset_model();
      mdl[1] = reset_model();
      cyc();
      rst = 1'b0;
      cyc();

      // lone zero-wait read
      set_m(0, 1'b1, 1'b0, 16'h1234, 8'h00);
      mem_din = 8'hA5;
      cyc();
      cyc();
      set_m(0, 1'b0, 1'b0, 16'h1234, 8'h00);
      mem_din = 8'h3C;
      repeat (2) cyc();

      // continuous contention: alternation in rr, M0 dominance in fp
      set_m(0, 1'b1, 1'b0, 16'h0100, 8'h00);
      set_m(1, 1'b1, 1'b0, 16'h0200, 8'h00);
      for (int i = 0; i < 10; i++) begin
         mem_din = 8'(8'h10 + i);
         cyc();
      end

      // M0 pulses with gaps while M1 holds
      for (int i = 0; i < 12; i++) begin
         rd[0]   = (i % 3 != 2);
         mem_din = 8'(8'h40 + i);
         cyc();
      end
      set_m(0, 1'b0, 1'b0, '0, '0);
      set_m(1, 1'b0, 1'b0, '0, '0);
      repeat (2) cyc();

      // stretched write from M1
      set_m(1, 1'b0, 1'b1, 16'h8000, 8'h5A);
      mem_wait = 1'b1;
      mem_din  = 8'hEE;
      repeat (4) cyc();
      mem_wait = 1'b0;
      cyc();
      set_m(1, 1'b0, 1'b0, 16'h8000, 8'h5A);
      repeat (2) cyc();

      // abort of a waiting read
      set_m(0, 1'b1, 1'b0, 16'h2222, 8'h00);
      mem_wait = 1'b1;
      repeat (3) cyc();
      set_m(0, 1'b0, 1'b0, 16'h2222, 8'h00);
      mem_wait = 1'b0;
      repeat (2) cyc();

      // reset while M1 owns the bus
      set_m(1, 1'b1, 1'b0, 16'h4444, 8'h00);
      mem_wait = 1'b1;
      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_m(1, 1'b0, 1'b0, '0, '0);
      mem_wait = 1'b0;
      repeat (2) cyc();

      for (int i = 0; i < 3000; i++) rand_cycle();
      rst = 1'b0;
      cyc();

      @(negedge clk);
      #1;
      if (q_rr.size() != 0 || q_fp.size() != 0) begin
         n_err++;
         $display("FAIL drain got=%0d exp=0", q_rr.size() + q_fp.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
